// File: rtl/cue_shot_launcher.sv
// cue_shot_launcher
//   Converts the aim sight into a white-ball launch. While all balls are at
//   rest, holding the shoot key charges a power level; releasing the key fires
//   a shot whose velocity is the (clamped) sight-to-ball offset scaled by the
//   power. After the balls come to rest again a start-of-turn pulse is issued.
//
// Ports
//   clk                 system clock
//   resetN              asynchronous active-low reset
//   startOfFrame        one-cycle pulse per video frame
//   keyEnter            debounced shoot key level, 1 = pressed
//   stop0               1 = all balls stationary
//   topLeftX/Y_Sight    sight top-left position (11-bit signed)
//   topLeftX/Y_WhiteBall white ball top-left position (11-bit signed)
//   shotSpeedX/Y        launch speed, held until the next shot
//   shotValid           one-cycle strobe, speeds valid this cycle
//   startOfTurn         one-cycle pulse, a new turn may begin
//   power               current charge level for the HUD
//   charging            1 while charging
module cue_shot_launcher #(
  parameter int MAX_POWER       = 15,
  parameter int DELTA_MAX       = 64,
  parameter int SPEED_SHIFT     = 2,
  parameter int FRAMES_PER_STEP = 4,
  parameter int ROLL_GRACE      = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               keyEnter,
  input  logic               stop0,
  input  logic signed [10:0] topLeftX_Sight,
  input  logic signed [10:0] topLeftY_Sight,
  input  logic signed [10:0] topLeftX_WhiteBall,
  input  logic signed [10:0] topLeftY_WhiteBall,
  output logic signed [10:0] shotSpeedX,
  output logic signed [10:0] shotSpeedY,
  output logic               shotValid,
  output logic               startOfTurn,
  output logic [3:0]         power,
  output logic               charging
);

  localparam int FCW = $clog2(FRAMES_PER_STEP + 1);
  localparam int GW  = $clog2(ROLL_GRACE + 1);
  localparam logic signed [11:0] DMAX = 12'(DELTA_MAX);
  localparam logic signed [11:0] DMIN = -12'(DELTA_MAX);

  typedef enum logic [2:0] {WAIT_STOP, AIM, CHARGE, FIRE, ROLLING} state_t;

  state_t                state_q;
  logic                  key_q;
  logic [FCW-1:0]        frame_cnt_q;
  logic [GW-1:0]         grace_q;
  logic                  moved_q;
  logic [3:0]            power_q;
  logic signed [10:0]    speed_x_q;
  logic signed [10:0]    speed_y_q;
  logic                  shot_valid_q;
  logic                  start_turn_q;
  logic                  charging_q;

  logic                  key_rise;
  logic                  key_fall;
  logic [3:0]            power_inc;
  logic [GW-1:0]         grace_inc;
  logic signed [11:0]    dx_c;
  logic signed [11:0]    dy_c;
  logic signed [16:0]    prod_x;
  logic signed [16:0]    prod_y;
  logic signed [16:0]    shr_x;
  logic signed [16:0]    shr_y;
  logic signed [10:0]    speed_x_d;
  logic signed [10:0]    speed_y_d;

  assign key_rise = keyEnter & ~key_q;
  assign key_fall = ~keyEnter & key_q;

  assign power_inc = (power_q == 4'(MAX_POWER)) ? power_q : power_q + 4'd1;
  assign grace_inc = (grace_q == GW'(ROLL_GRACE)) ? grace_q : grace_q + GW'(1);

  // Offset computed one bit wider than the positions so it cannot wrap,
  // then clamped so the scaled result always fits 11 bits.
  function automatic logic signed [11:0] clamp_delta(input logic signed [10:0] a,
                                                     input logic signed [10:0] b);
    logic signed [11:0] d;
    d = {a[10], a} - {b[10], b};
    if (d > DMAX)      return DMAX;
    else if (d < DMIN) return DMIN;
    else               return d;
  endfunction

  assign dx_c = clamp_delta(topLeftX_Sight, topLeftX_WhiteBall);
  assign dy_c = clamp_delta(topLeftY_Sight, topLeftY_WhiteBall);

  assign prod_x = $signed({{5{dx_c[11]}}, dx_c}) * $signed({13'd0, power_q});
  assign prod_y = $signed({{5{dy_c[11]}}, dy_c}) * $signed({13'd0, power_q});
  // Arithmetic shift: negative speeds round toward -inf.
  assign shr_x  = prod_x >>> SPEED_SHIFT;
  assign shr_y  = prod_y >>> SPEED_SHIFT;
  assign speed_x_d = shr_x[10:0];
  assign speed_y_d = shr_y[10:0];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= WAIT_STOP;
      key_q        <= 1'b0;
      frame_cnt_q  <= '0;
      grace_q      <= '0;
      moved_q      <= 1'b0;
      power_q      <= 4'd0;
      speed_x_q    <= '0;
      speed_y_q    <= '0;
      shot_valid_q <= 1'b0;
      start_turn_q <= 1'b0;
      charging_q   <= 1'b0;
    end else begin
      key_q        <= keyEnter;
      shot_valid_q <= 1'b0;
      start_turn_q <= 1'b0;
      case (state_q)
        WAIT_STOP: begin
          if (startOfFrame && stop0) begin
            state_q      <= AIM;
            start_turn_q <= 1'b1;
          end
        end
        AIM: begin
          if (!stop0) begin
            state_q <= WAIT_STOP;
          end else if (key_rise) begin
            // Only a fresh press charges; a key held from the previous turn does not.
            state_q     <= CHARGE;
            power_q     <= 4'd1;
            frame_cnt_q <= '0;
            charging_q  <= 1'b1;
          end
        end
        CHARGE: begin
          if (!stop0) begin
            // Abort has priority over a release in the same cycle.
            state_q    <= WAIT_STOP;
            power_q    <= 4'd0;
            charging_q <= 1'b0;
          end else if (key_fall) begin
            state_q      <= FIRE;
            charging_q   <= 1'b0;
            shot_valid_q <= 1'b1;
            speed_x_q    <= speed_x_d;
            speed_y_q    <= speed_y_d;
          end else if (startOfFrame) begin
            if (frame_cnt_q == FCW'(FRAMES_PER_STEP - 1)) begin
              frame_cnt_q <= '0;
              power_q     <= power_inc;
            end else begin
              frame_cnt_q <= frame_cnt_q + FCW'(1);
            end
          end
        end
        FIRE: begin
          state_q <= ROLLING;
          power_q <= 4'd0;
          grace_q <= '0;
          moved_q <= 1'b0;
        end
        ROLLING: begin
          if (!stop0) moved_q <= 1'b1;
          if (startOfFrame) begin
            grace_q <= grace_inc;
            // The grace path releases the turn after a zero-speed shot where
            // stop0 never drops.
            if (stop0 && (moved_q || grace_inc >= GW'(ROLL_GRACE))) begin
              state_q <= WAIT_STOP;
            end
          end
        end
        default: state_q <= WAIT_STOP;
      endcase
    end
  end

  assign shotSpeedX  = speed_x_q;
  assign shotSpeedY  = speed_y_q;
  assign shotValid   = shot_valid_q;
  assign startOfTurn = start_turn_q;
  assign power       = power_q;
  assign charging    = charging_q;

endmodule

// File: tb/tb_cue_shot_launcher.sv
// Testbench for cue_shot_launcher: directed scenarios with a scoreboard of
// expected shot / start-of-turn events checked by an independent monitor.
module tb_cue_shot_launcher;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic               keyEnter;
  logic               stop0;
  logic signed [10:0] topLeftX_Sight;
  logic signed [10:0] topLeftY_Sight;
  logic signed [10:0] topLeftX_WhiteBall;
  logic signed [10:0] topLeftY_WhiteBall;
  logic signed [10:0] shotSpeedX;
  logic signed [10:0] shotSpeedY;
  logic               shotValid;
  logic               startOfTurn;
  logic [3:0]         power;
  logic               charging;

  cue_shot_launcher dut (
    .clk                (clk),
    .resetN             (resetN),
    .startOfFrame       (startOfFrame),
    .keyEnter           (keyEnter),
    .stop0              (stop0),
    .topLeftX_Sight     (topLeftX_Sight),
    .topLeftY_Sight     (topLeftY_Sight),
    .topLeftX_WhiteBall (topLeftX_WhiteBall),
    .topLeftY_WhiteBall (topLeftY_WhiteBall),
    .shotSpeedX         (shotSpeedX),
    .shotSpeedY         (shotSpeedY),
    .shotValid          (shotValid),
    .startOfTurn        (startOfTurn),
    .power              (power),
    .charging           (charging)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_shot;
    int x;
    int y;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end else begin
      $display("ok   %s: %0d", name, actual);
    end
  endtask

  task automatic push_shot(input int x, input int y);
    exp_t e;
    e.is_shot = 1'b1; e.x = x; e.y = y;
    exp_q.push_back(e);
  endtask

  task automatic push_turn();
    exp_t e;
    e.is_shot = 1'b0; e.x = 0; e.y = 0;
    exp_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each strobe.
  always @(negedge clk) begin
    if (resetN) begin
      if (shotValid && startOfTurn) begin
        n_vec++; n_bad++;
        $display("FAIL strobes_together: shotValid=1 startOfTurn=1 required not both");
      end
      if (shotValid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_shot: got shot (%0d,%0d) required none",
                   shotSpeedX, shotSpeedY);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (!e.is_shot || int'(shotSpeedX) != e.x || int'(shotSpeedY) != e.y) begin
            n_bad++;
            $display("FAIL shot: got (%0d,%0d) required is_shot=%0d (%0d,%0d)",
                     shotSpeedX, shotSpeedY, e.is_shot, e.x, e.y);
          end else begin
            $display("ok   shot: (%0d,%0d)", shotSpeedX, shotSpeedY);
          end
        end
      end
      if (startOfTurn) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_turn: got startOfTurn required none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.is_shot) begin
            n_bad++;
            $display("FAIL turn: got startOfTurn required shot (%0d,%0d)", e.x, e.y);
          end else begin
            $display("ok   turn: startOfTurn");
          end
        end
      end
    end
  end

  // Advance n rising edges, then step off the edge before driving/sampling.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    tick(2);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic set_pos(input int sx, input int sy, input int bx, input int by);
    topLeftX_Sight     = 11'(sx);
    topLeftY_Sight     = 11'(sy);
    topLeftX_WhiteBall = 11'(bx);
    topLeftY_WhiteBall = 11'(by);
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; keyEnter = 1'b0; stop0 = 1'b1;
    set_pos(0, 0, 0, 0);
    #2;
    check("rst_speedX",   int'(shotSpeedX), 0);
    check("rst_speedY",   int'(shotSpeedY), 0);
    check("rst_valid",    int'(shotValid), 0);
    check("rst_turn",     int'(startOfTurn), 0);
    check("rst_power",    int'(power), 0);
    check("rst_charging", int'(charging), 0);
    tick(2);
    resetN = 1'b1;
    tick(1);

    // First turn.
    push_turn();
    frame();
    check("aim_power", int'(power), 0);
    check("aim_charging", int'(charging), 0);

    // Shot 1: offset (32,0), 16 frames -> power 5, speed (40,0).
    set_pos(472, 224, 440, 224);
    keyEnter = 1'b1;
    tick(2);
    check("charge1_charging", int'(charging), 1);
    check("charge1_power_start", int'(power), 1);
    frames(16);
    check("charge1_power", int'(power), 5);
    push_shot(40, 0);
    keyEnter = 1'b0;
    tick(3);
    check("post_shot1_power", int'(power), 0);
    check("post_shot1_charging", int'(charging), 0);
    stop0 = 1'b0;
    frame();
    stop0 = 1'b1;
    push_turn();
    frames(2);

    // Shot 2: both axes clamp to -64, power saturates at 15 -> -240.
    set_pos(300, 100, 440, 224);
    keyEnter = 1'b1;
    tick(2);
    frames(64);
    check("charge2_power_sat", int'(power), 15);
    push_shot(-240, -240);
    keyEnter = 1'b0;
    tick(3);
    stop0 = 1'b0;
    frame();
    stop0 = 1'b1;
    push_turn();
    frames(2);

    // Abort: release and stop0 drop together -> no shot.
    keyEnter = 1'b1;
    tick(2);
    frames(5);
    check("abort_power_before", int'(power), 2);
    keyEnter = 1'b0;
    stop0 = 1'b0;
    tick(1);
    check("abort_power", int'(power), 0);
    check("abort_charging", int'(charging), 0);
    tick(3);
    stop0 = 1'b1;
    push_turn();
    frame();

    // Zero-offset shot: stop0 stays 1, grace timeout ends the roll.
    set_pos(440, 224, 440, 224);
    keyEnter = 1'b1;
    tick(2);
    push_shot(0, 0);
    keyEnter = 1'b0;
    tick(3);
    push_turn();
    frames(4);

    // Key held through startOfTurn does not charge.
    stop0 = 1'b0;
    tick(1);
    keyEnter = 1'b1;
    tick(2);
    stop0 = 1'b1;
    push_turn();
    frames(3);
    check("held_charging", int'(charging), 0);
    check("held_power", int'(power), 0);
    keyEnter = 1'b0;
    tick(2);
    check("held_release_charging", int'(charging), 0);
    keyEnter = 1'b1;
    tick(2);
    check("repress_charging", int'(charging), 1);
    check("repress_power", int'(power), 1);

    // Reset mid-charge.
    frames(8);
    check("precut_power", int'(power), 3);
    resetN = 1'b0;
    #2;
    check("midrst_power", int'(power), 0);
    check("midrst_charging", int'(charging), 0);
    check("midrst_speedX", int'(shotSpeedX), 0);
    check("midrst_valid", int'(shotValid), 0);
    keyEnter = 1'b0;
    tick(2);
    resetN = 1'b1;
    tick(1);
    push_turn();
    frame();

    tick(20);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
